mem_dump_uart: RTL and testbench

- Reverse-direction companion to the UART program loader: it reads a range of the external 21-bit cartridge/RAM bus and streams each byte out over UART TX (8N1), then appends an 8-bit checksum.
- Sits at top level in the programming-mode path, on the fast board clock, sharing adr/n_read with the CPU path through the existing top-level mux.
- The host paces the stream with an active-low clear-to-send input.

---
 rtl/mem_dump_uart.sv | 166 ++++++++++++++++
 tb/tb_mem_dump_uart.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_uart.sv
// Streams a range of the external 21-bit bus out over an 8N1 UART, followed by
// an 8-bit additive checksum. The host paces each frame with an active-low CTS.
module mem_dump_uart #(
  parameter int CLKS_PER_BIT = 104,
  parameter int READ_WAIT    = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic [20:0] base_adr,
  input  logic [20:0] length,
  output logic [20:0] adr,
  output logic        read,
  input  logic [7:0]  din,
  input  logic        n_cts,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int WW = $clog2(READ_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT_CTS, S_START_BIT, S_DATA_BITS, S_STOP_BIT, S_DONE
  } state_t;

  state_t        r_state;
  logic [20:0]   r_adr;
  logic [20:0]   r_remaining;
  logic [7:0]    r_sum;
  logic [7:0]    r_shift;
  logic          r_is_sum;
  logic [2:0]    r_bit_cnt;
  logic [CW-1:0] r_clk_cnt;
  logic [WW-1:0] r_wait_cnt;
  logic          r_read;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;
  logic [1:0]    r_cts_sync;

  logic          w_bit_end;
  logic [20:0]   w_remaining_dec;

  assign w_bit_end       = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_remaining_dec = r_remaining - 21'd1;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= S_IDLE;
      r_adr       <= '0;
      r_remaining <= '0;
      r_sum       <= '0;
      r_shift     <= '0;
      r_is_sum    <= 1'b0;
      r_bit_cnt   <= '0;
      r_clk_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_read      <= 1'b0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cts_sync  <= 2'b11;
    end else begin
      r_cts_sync <= {r_cts_sync[0], n_cts};
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_adr       <= base_adr;
            r_remaining <= length;
            r_sum       <= '0;
            r_shift     <= '0;
            r_is_sum    <= (length == 21'd0);
            r_wait_cnt  <= '0;
            r_read      <= (length != 21'd0);
            r_busy      <= 1'b1;
            r_state     <= (length != 21'd0) ? S_READ : S_WAIT_CTS;
          end
        end
        S_READ: begin
          if (r_wait_cnt == WW'(READ_WAIT - 1)) begin
            r_shift <= din;
            r_sum   <= r_sum + din;
            r_read  <= 1'b0;
            r_state <= S_WAIT_CTS;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_WAIT_CTS: begin
          if (!r_cts_sync[1]) begin
            r_tx      <= 1'b0;
            r_clk_cnt <= '0;
            r_state   <= S_START_BIT;
          end
        end
        S_START_BIT: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_state   <= S_DATA_BITS;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA_BITS: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP_BIT;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP_BIT: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_is_sum) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              // The address register wraps naturally at 21 bits.
              r_adr       <= r_adr + 21'd1;
              r_remaining <= w_remaining_dec;
              if (w_remaining_dec != 21'd0) begin
                r_read     <= 1'b1;
                r_wait_cnt <= '0;
                r_state    <= S_READ;
              end else begin
                r_shift  <= r_sum;
                r_is_sum <= 1'b1;
                r_state  <= S_WAIT_CTS;
              end
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign adr  = r_adr;
  assign read = r_read;
  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_mem_dump_uart.sv
// Bench for mem_dump_uart: memory model on the bus, UART frame decoder, read-pulse
// monitor and a queue-based reference of the expected byte stream.
module tb_mem_dump_uart;

  localparam int CPB = 104;
  localparam int RW  = 2;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        start;
  logic [20:0] base_adr;
  logic [20:0] length;
  logic [20:0] adr;
  logic        read;
  logic [7:0]  din;
  logic        n_cts;
  logic        tx;
  logic        busy;
  logic        done;

  mem_dump_uart #(.CLKS_PER_BIT(CPB), .READ_WAIT(RW)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .base_adr(base_adr),
    .length(length), .adr(adr), .read(read), .din(din), .n_cts(n_cts),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  assign din = mem[adr[7:0]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // UART decoder: every cycle of every bit must hold the same level.
  logic [7:0] rx_q [$];
  logic [9:0] dec_bits;
  bit         dec_ok, dec_abort;
  initial begin
    forever begin
      @(negedge clk);
      if (n_reset === 1'b1 && tx === 1'b0) begin
        dec_ok = 1; dec_abort = 0; dec_bits = '0;
        for (int s = 0; s < 10 * CPB; s++) begin
          if (s != 0) @(negedge clk);
          if (n_reset !== 1'b1) begin
            dec_abort = 1;
            break;
          end
          if (s % CPB == 0) dec_bits[s / CPB] = tx;
          else if (tx !== dec_bits[s / CPB]) dec_ok = 0;
        end
        if (!dec_abort) begin
          check("frame_shape", {29'd0, dec_ok, dec_bits[0], dec_bits[9]}, 32'd5);
          rx_q.push_back(dec_bits[8:1]);
        end
      end
    end
  end

  typedef struct packed {
    logic [20:0] adr;
    logic [7:0]  len;
    logic        stable;
  } rd_t;
  rd_t  rd_q [$];
  rd_t  rd_cur;
  bit   rd_in = 0;
  always @(negedge clk) begin
    if (read === 1'b1) begin
      if (!rd_in) begin
        rd_in = 1; rd_cur.adr = adr; rd_cur.len = 8'd1; rd_cur.stable = 1'b1;
      end else begin
        rd_cur.len = rd_cur.len + 8'd1;
        if (adr !== rd_cur.adr) rd_cur.stable = 1'b0;
      end
    end else if (rd_in) begin
      rd_in = 0;
      rd_q.push_back(rd_cur);
    end
  end

  int done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Reference model: expected stream computed from the address/length rules.
  logic [7:0]  exp_bytes [$];
  logic [20:0] exp_adrs  [$];
  logic [20:0] exp_end;
  int          done0;
  int          exp_len;

  task automatic start_dump(input logic [20:0] base, input logic [20:0] len);
    logic [7:0]  s;
    logic [20:0] a;
    s = 8'd0;
    exp_bytes.delete(); exp_adrs.delete(); rx_q.delete(); rd_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      a = base + 21'(i);
      exp_adrs.push_back(a);
      exp_bytes.push_back(mem[a[7:0]]);
      s = s + mem[a[7:0]];
    end
    exp_bytes.push_back(s);
    exp_end = base + len;
    exp_len = int'(len);
    done0   = done_cnt;
    @(negedge clk);
    base_adr = base; length = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic finish_dump();
    bit seen;
    int bound;
    int n;
    seen  = 0;
    bound = (exp_len + 1) * (10 * CPB + 40) + 2000;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      check("busy_at_done", {31'd0, busy}, 32'd0);
      check("adr_at_done", {11'd0, adr}, {11'd0, exp_end});
      @(negedge clk);
      check("done_width", {31'd0, done}, 32'd0);
    end
    repeat (5) @(negedge clk);
    check("rx_count", rx_q.size(), exp_bytes.size());
    n = (rx_q.size() < exp_bytes.size()) ? rx_q.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) check("rx_byte", {24'd0, rx_q[i]}, {24'd0, exp_bytes[i]});
    check("read_count", rd_q.size(), exp_adrs.size());
    n = (rd_q.size() < exp_adrs.size()) ? rd_q.size() : exp_adrs.size();
    for (int i = 0; i < n; i++) begin
      check("read_adr", {11'd0, rd_q[i].adr}, {11'd0, exp_adrs[i]});
      check("read_len", {24'd0, rd_q[i].len}, RW);
      check("read_stable", {31'd0, rd_q[i].stable}, 32'd1);
    end
    check("done_pulses", done_cnt - done0, 32'd1);
    $display("dump base=0x%06h len=%0d bytes=%0d reads=%0d", exp_end - 21'(exp_len), exp_len, rx_q.size(), rd_q.size());
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  typedef struct {
    logic [20:0] base;
    logic [20:0] len;
    logic [23:0] data;
    logic [7:0]  exp_sum;
  } vec_t;
  vec_t vecs [3];

  initial begin
    int          k;
    int          lows;
    int          reads_seen;
    logic [20:0] a;
    logic [20:0] rb;
    logic [20:0] rl;

    vecs[0] = '{base: 21'h000100, len: 21'd3, data: 24'hFF3412, exp_sum: 8'h45};
    vecs[1] = '{base: 21'h0ABCDE, len: 21'd0, data: 24'h000000, exp_sum: 8'h00};
    vecs[2] = '{base: 21'h1FFFFE, len: 21'd3, data: 24'h030201, exp_sum: 8'h06};

    fill_random();
    n_reset = 1'b0; start = 1'b0; base_adr = '0; length = '0; n_cts = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_read", {31'd0, read}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_adr", {11'd0, adr}, 32'd0);
    n_reset = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      fill_random();
      for (int i = 0; i < int'(vecs[v].len); i++) begin
        a = vecs[v].base + 21'(i);
        mem[a[7:0]] = vecs[v].data[8*i +: 8];
      end
      start_dump(vecs[v].base, vecs[v].len);
      finish_dump();
      if (rx_q.size() > 0) check("table_checksum", {24'd0, rx_q[rx_q.size()-1]}, {24'd0, vecs[v].exp_sum});
      repeat (20) @(negedge clk);
    end

    for (int r = 0; r < 4; r++) begin
      fill_random();
      rb = ($urandom_range(0, 1) == 1) ? 21'h1FFFFF - 21'($urandom_range(0, 3)) : 21'($urandom);
      rl = 21'($urandom_range(0, 3));
      start_dump(rb, rl);
      finish_dump();
      repeat (20) @(negedge clk);
    end

    // Flow control: CTS withheld at start, then dropped again mid-frame.
    fill_random();
    n_cts = 1'b1;
    start_dump(21'h000040, 21'd2);
    lows = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("cts_hold_idle", lows, 32'd0);
    n_cts = 1'b0;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      k++;
      if (tx === 1'b0) break;
    end
    check("cts_release_latency", {31'd0, (k >= 2 && k <= 3)}, 32'd1);
    repeat (300) @(negedge clk);
    n_cts = 1'b1;
    k = 0;
    while (rx_q.size() < 1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("cts_byte0_done", rx_q.size(), 32'd1);
    lows = 0;
    repeat (600) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("cts_byte1_withheld", lows, 32'd0);
    check("cts_still_one_byte", rx_q.size(), 32'd1);
    n_cts = 1'b0;
    finish_dump();
    repeat (20) @(negedge clk);

    // Reset inside the 4th data bit of byte 1 (bit 3 forced low so tx is 0 there).
    fill_random();
    mem[8'h11] = mem[8'h11] & 8'hF7;
    start_dump(21'h000010, 21'd3);
    k = 0;
    while (rx_q.size() < 1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (tx !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    check("pre_reset_tx_low", {31'd0, tx}, 32'd0);
    #2 n_reset = 1'b0;
    #1;
    check("async_rst_tx", {31'd0, tx}, 32'd1);
    check("async_rst_read", {31'd0, read}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    done0 = done_cnt;
    lows = 0; reads_seen = 0;
    repeat (3000) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (read !== 1'b0) reads_seen++;
    end
    check("post_reset_tx_idle", lows, 32'd0);
    check("post_reset_no_read", reads_seen, 32'd0);
    check("post_reset_no_done", done_cnt - done0, 32'd0);
    check("post_reset_adr", {11'd0, adr}, 32'd0);
    $display("reset abort checked, tx lows after release=%0d", lows);

    // Start pulses every 50 cycles while busy must all be ignored.
    fill_random();
    start_dump(21'h000020, 21'd2);
    fork
      begin
        forever begin
          repeat (50) @(negedge clk);
          if (busy !== 1'b1) break;
          base_adr = 21'($urandom); length = 21'($urandom_range(1, 5)); start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
      finish_dump();
    join
    done0 = done_cnt;
    repeat (300) @(negedge clk);
    check("ignored_start_no_extra_done", done_cnt - done0, 32'd0);
    check("ignored_start_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
